gpu_mem_fifo_lvl: RTL and testbench
===================================

GPU_MEM_FIFO_LVL -- requirements
Module: gpu_mem_fifo_lvl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: total entry capacity; SHALL equal 2**ADDR_W.
REQ-003 SHALL have parameter ADDR_W, default 4: pointer width.
REQ-004 SHALL have parameter AFULL_LVL, default 12: almost-full threshold, range 1..DEPTH.
REQ-005 SHALL have parameter AEMPTY_LVL, default 2: almost-empty threshold, range 0..DEPTH-1.
REQ-006 SHALL have parameter OUT_REG, default 0: 0 = combinational show-ahead output; 1 = registered output stage.
REQ-007 SHALL have ports, in this order:
- clk_i, input, 1: sole clock, rising edge.
- rst_i, input, 1: asynchronous active-high reset.
- data_in_i, input, WIDTH: push data.
- push_i, input, 1: push request.
- pop_i, input, 1: pop request.
- flush_i, input, 1: synchronous discard of all contents.
- err_clr_i, input, 1: clears sticky error flags.
- data_out_o, output, WIDTH: head-of-queue data.
- accept_o, output, 1: space available.
- valid_o, output, 1: head data valid.
- level_o, output, ADDR_W+1: entries held.
- almost_full_o, output, 1: level_o >= AFULL_LVL.
- almost_empty_o, output, 1: level_o <= AEMPTY_LVL.
- overflow_o, output, 1: sticky; set on a rejected push.
- underflow_o, output, 1: sticky; set on a rejected pop.

Function
REQ-008 SHALL drive accept_o = (level_o != DEPTH) and almost_full_o/almost_empty_o combinationally from the level register only.
REQ-009 SHALL accept a push iff push_i & accept_o & ~flush_i; an accepted push writes data_in_i at the write pointer, which then increments.
REQ-010 SHALL accept a pop iff pop_i & valid_o & ~flush_i.
REQ-011 SHALL wrap pointers modulo DEPTH with no special case.
REQ-012 SHALL, on a simultaneous accepted push and pop, leave level_o unchanged.
REQ-013 SHALL, when full with push_i & pop_i asserted, accept the pop, reject the push, and set overflow_o; level becomes DEPTH-1.
REQ-014 SHALL, when empty with push_i & pop_i asserted, accept the push, reject the pop, and set underflow_o; level becomes 1.
REQ-015 SHALL, with OUT_REG=0, drive data_out_o = ram[rd_ptr] and valid_o = (level_o != 0); push to pop-ready latency is 1 cycle.
REQ-016 SHALL, with OUT_REG=1, hold the head in an output register loaded from RAM whenever the register is empty or being popped and RAM holds an entry.
REQ-017 SHALL, with OUT_REG=1, drive valid_o = output-register-occupied; push-to-empty to valid_o latency is 2 cycles.
REQ-018 SHALL, with OUT_REG=1, count the output register in level_o; total capacity stays DEPTH.
REQ-019 SHALL, with OUT_REG=1, sustain 1 push and 1 pop per cycle with no bubble once valid_o is high.
REQ-020 SHALL, on flush_i, next cycle zero level_o, pointers and output-register occupancy, and ignore same-cycle push_i/pop_i without flagging errors.
REQ-021 SHALL leave overflow_o/underflow_o unaffected by flush_i.
REQ-022 SHALL clear overflow_o/underflow_o on err_clr_i; a new error in the same cycle wins (flag set).
REQ-023 SHALL hold data_out_o stable while valid_o=1 and no pop is accepted; data_out_o is don't-care when valid_o=0.

Reset
REQ-024 SHALL, while rst_i=1 (asynchronous), force level_o=0, pointers=0, output register empty, valid_o=0, accept_o=1, almost_empty_o=1, almost_full_o=0, overflow_o=0, underflow_o=0.
REQ-025 SHALL discard all contents on reset asserted mid-operation; RAM contents are not reset.
REQ-026 SHALL deassert reset synchronously to clk_i.

Structure
REQ-027 SHALL place level/threshold width helpers and the OUT_REG mode constants in shared package gpu_mem_pkg.
REQ-028 SHALL implement storage as sub-module gpu_mem_fifo_ram (1 write port, 1 asynchronous read port, no reset).
REQ-029 SHALL contain control, level, flags and output stage in gpu_mem_fifo_lvl.
REQ-030 SHALL fail elaboration if DEPTH != 2**ADDR_W, or if AFULL_LVL/AEMPTY_LVL is out of range.

Verification
REQ-031 Fill/drain, DEPTH=16, OUT_REG=0: push 0..15 -> accept_o=0 at level 16, almost_full_o from level 12; pop all -> data 0..15 in order, almost_empty_o at level <= 2.
REQ-032 Full, push+pop same cycle -> head popped, push rejected, overflow_o=1, level_o=15.
REQ-033 Empty, push+pop same cycle -> underflow_o=1, level_o=1; err_clr_i -> both flags 0.
REQ-034 OUT_REG=1, push 0xA5 into empty -> valid_o high 2 cycles later with data_out_o=0xA5; 40-cycle continuous push+pop -> no bubbles, ordered data.
REQ-035 Level 9 with flush_i+push_i -> level_o=0, valid_o=0 next cycle, error flags unchanged.
REQ-036 rst_i asserted mid-burst between clock edges -> outputs reach reset values immediately; wrap test of 3xDEPTH pushes after reset -> data correct.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// Shared constants and helpers for the gpu_mem FIFO family: output-stage
// mode encodings and level/threshold width helpers.
package gpu_mem_pkg;

  localparam int OUT_REG_COMB = 0;
  localparam int OUT_REG_REGD = 1;

  // Level counter needs one extra bit to represent a completely full queue.
  function automatic int lvl_width(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic bit thresh_in_range(input int lvl, input int lo, input int hi);
    return (lvl >= lo) && (lvl <= hi);
  endfunction

endpackage

// File: rtl/gpu_mem_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port,
// contents are never reset.
module gpu_mem_fifo_ram
  import gpu_mem_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gpu_mem_fifo_lvl.sv
// Level-tracking FIFO with almost-full/empty thresholds, sticky error flags,
// synchronous flush and an optional registered show-ahead output stage.
module gpu_mem_fifo_lvl
  import gpu_mem_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2,
  parameter int OUT_REG    = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WIDTH-1:0]  data_in_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic              err_clr_i,
  output logic [WIDTH-1:0]  data_out_o,
  output logic              accept_o,
  output logic              valid_o,
  output logic [ADDR_W:0]   level_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int LVL_W = lvl_width(ADDR_W);
  localparam logic [LVL_W-1:0] FULL_L   = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AFULL_L  = LVL_W'(AFULL_LVL);
  localparam logic [LVL_W-1:0] AEMPTY_L = LVL_W'(AEMPTY_LVL);

  if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
    $error("gpu_mem_fifo_lvl: DEPTH must equal 2**ADDR_W");
  end
  if (!thresh_in_range(AFULL_LVL, 1, DEPTH)) begin : g_bad_afull
    $error("gpu_mem_fifo_lvl: AFULL_LVL out of range 1..DEPTH");
  end
  if (!thresh_in_range(AEMPTY_LVL, 0, DEPTH - 1)) begin : g_bad_aempty
    $error("gpu_mem_fifo_lvl: AEMPTY_LVL out of range 0..DEPTH-1");
  end
  if ((OUT_REG != OUT_REG_COMB) && (OUT_REG != OUT_REG_REGD)) begin : g_bad_mode
    $error("gpu_mem_fifo_lvl: OUT_REG must be 0 or 1");
  end

  logic [LVL_W-1:0]  level;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              overflow;
  logic              underflow;
  logic [WIDTH-1:0]  ram_rdata;
  logic              accept;
  logic              valid;
  logic              push_acc;
  logic              pop_acc;
  logic              ram_rd;
  logic              ovf_set;
  logic              udf_set;

  assign accept   = (level != FULL_L);
  assign push_acc = push_i & accept & ~flush_i;
  assign pop_acc  = pop_i & valid & ~flush_i;
  assign ovf_set  = push_i & ~accept & ~flush_i;
  assign udf_set  = pop_i & ~valid & ~flush_i;

  gpu_mem_fifo_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk_i),
    .we    (push_acc),
    .waddr (wr_ptr),
    .wdata (data_in_i),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  if (OUT_REG == OUT_REG_REGD) begin : g_out_reg
    logic             oreg_valid;
    logic [WIDTH-1:0] oreg;
    logic [LVL_W-1:0] ram_level;

    // level counts the output register, so RAM occupancy is level minus it.
    assign ram_level = level - LVL_W'(oreg_valid);
    assign ram_rd    = (ram_level != '0) & (~oreg_valid | pop_acc) & ~flush_i;
    assign valid     = oreg_valid;
    assign data_out_o = oreg;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        oreg_valid <= 1'b0;
      end else if (flush_i) begin
        oreg_valid <= 1'b0;
      end else if (ram_rd) begin
        oreg_valid <= 1'b1;
      end else if (pop_acc) begin
        oreg_valid <= 1'b0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (ram_rd) oreg <= ram_rdata;
    end
  end else begin : g_out_comb
    assign ram_rd     = pop_acc;
    assign valid      = (level != '0);
    assign data_out_o = ram_rdata;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      level  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      level  <= level + LVL_W'(push_acc) - LVL_W'(pop_acc);
      wr_ptr <= wr_ptr + ADDR_W'(push_acc);
      rd_ptr <= rd_ptr + ADDR_W'(ram_rd);
    end
  end

  // A new error in the same cycle as err_clr_i keeps the flag set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)        overflow  <= 1'b1;
      else if (err_clr_i) overflow  <= 1'b0;
      if (udf_set)        underflow <= 1'b1;
      else if (err_clr_i) underflow <= 1'b0;
    end
  end

  assign accept_o       = accept;
  assign valid_o        = valid;
  assign level_o        = level;
  assign almost_full_o  = (level >= AFULL_L);
  assign almost_empty_o = (level <= AEMPTY_L);
  assign overflow_o     = overflow;
  assign underflow_o    = underflow;

endmodule

// File: tb/tb_gpu_mem_fifo_lvl.sv
// Directed bench for gpu_mem_fifo_lvl: one instance per output-stage mode,
// expected values hand-computed per step.
module tb_gpu_mem_fifo_lvl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [15:0] d0_in = '0;
  logic        push0 = 1'b0, pop0 = 1'b0, flush0 = 1'b0, clr0 = 1'b0;
  logic [15:0] d0_out;
  logic        acc0, val0, af0, ae0, ovf0, udf0;
  logic [4:0]  lvl0;

  logic [15:0] d1_in = '0;
  logic        push1 = 1'b0, pop1 = 1'b0, flush1 = 1'b0, clr1 = 1'b0;
  logic [15:0] d1_out;
  logic        acc1, val1, af1, ae1, ovf1, udf1;
  logic [4:0]  lvl1;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  gpu_mem_fifo_lvl #(
    .WIDTH(16), .DEPTH(16), .ADDR_W(4), .AFULL_LVL(12), .AEMPTY_LVL(2), .OUT_REG(0)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst), .data_in_i(d0_in), .push_i(push0), .pop_i(pop0),
    .flush_i(flush0), .err_clr_i(clr0), .data_out_o(d0_out), .accept_o(acc0),
    .valid_o(val0), .level_o(lvl0), .almost_full_o(af0), .almost_empty_o(ae0),
    .overflow_o(ovf0), .underflow_o(udf0)
  );

  gpu_mem_fifo_lvl #(
    .WIDTH(16), .DEPTH(16), .ADDR_W(4), .AFULL_LVL(12), .AEMPTY_LVL(2), .OUT_REG(1)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst), .data_in_i(d1_in), .push_i(push1), .pop_i(pop1),
    .flush_i(flush1), .err_clr_i(clr1), .data_out_o(d1_out), .accept_o(acc1),
    .valid_o(val1), .level_o(lvl1), .almost_full_o(af1), .almost_empty_o(ae1),
    .overflow_o(ovf1), .underflow_o(udf1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while rst is held
    #1;
    chk("rst_lvl0", lvl0, 0);   chk("rst_val0", val0, 0);
    chk("rst_acc0", acc0, 1);   chk("rst_ae0", ae0, 1);
    chk("rst_af0", af0, 0);     chk("rst_ovf0", ovf0, 0);
    chk("rst_udf0", udf0, 0);   chk("rst_val1", val1, 0);
    chk("rst_lvl1", lvl1, 0);   chk("rst_acc1", acc1, 1);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Fill 0..15 (OUT_REG=0)
    push0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d0_in = 16'(i);
      chk("fill_lvl", lvl0, i);
      chk("fill_af", af0, (i >= 12) ? 1 : 0);
      chk("fill_ae", ae0, (i <= 2) ? 1 : 0);
      chk("fill_acc", acc0, 1);
      tick();
    end
    push0 = 1'b0;
    chk("full_lvl", lvl0, 16); chk("full_acc", acc0, 0);
    chk("full_af", af0, 1);    chk("full_head", d0_out, 0);

    // Full with push+pop: pop wins, push rejected
    d0_in = 16'h0099; push0 = 1'b1; pop0 = 1'b1;
    tick();
    push0 = 1'b0; pop0 = 1'b0;
    chk("fpp_lvl", lvl0, 15);  chk("fpp_ovf", ovf0, 1);
    chk("fpp_udf", udf0, 0);   chk("fpp_head", d0_out, 1);

    // Drain remaining 1..15 in order
    pop0 = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("drain_data", d0_out, i);
      chk("drain_ae", ae0, ((16 - i) <= 2) ? 1 : 0);
      tick();
    end
    pop0 = 1'b0;
    chk("empty_lvl", lvl0, 0); chk("empty_val", val0, 0); chk("empty_ae", ae0, 1);

    // Empty with push+pop: push wins, pop rejected
    d0_in = 16'h0077; push0 = 1'b1; pop0 = 1'b1;
    tick();
    push0 = 1'b0; pop0 = 1'b0;
    chk("epp_udf", udf0, 1);  chk("epp_lvl", lvl0, 1);
    chk("epp_val", val0, 1);  chk("epp_data", d0_out, 16'h0077);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    chk("clr_ovf", ovf0, 0);  chk("clr_udf", udf0, 0); chk("clr_lvl", lvl0, 1);
    pop0 = 1'b1;
    tick();
    chk("pop_last_lvl", lvl0, 0);
    clr0 = 1'b1;
    tick();
    pop0 = 1'b0;
    chk("clr_vs_err", udf0, 1);
    tick();
    clr0 = 1'b0;
    chk("clr_after", udf0, 0);

    // Flush at level 9 with push/pop; underflow flag must survive
    pop0 = 1'b1;
    tick();
    pop0 = 1'b0;
    chk("pre_flush_udf", udf0, 1);
    push0 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      d0_in = 16'(16'h10 + i);
      tick();
    end
    chk("pre_flush_lvl", lvl0, 9);
    flush0 = 1'b1; pop0 = 1'b1; d0_in = 16'h00EE;
    tick();
    flush0 = 1'b0; pop0 = 1'b0; push0 = 1'b0;
    chk("flush_lvl", lvl0, 0);  chk("flush_val", val0, 0);
    chk("flush_udf", udf0, 1);  chk("flush_ovf", ovf0, 0);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    chk("flush_clr", udf0, 0);

    // OUT_REG=1: push into empty, valid two cycles later
    d1_in = 16'h00A5; push1 = 1'b1;
    tick();
    push1 = 1'b0;
    chk("or_val_c1", val1, 0); chk("or_lvl_c1", lvl1, 1);
    tick();
    chk("or_val_c2", val1, 1); chk("or_data_c2", d1_out, 16'h00A5);
    chk("or_lvl_c2", lvl1, 1);
    pop1 = 1'b1;
    tick();
    pop1 = 1'b0;
    chk("or_pop_lvl", lvl1, 0); chk("or_pop_val", val1, 0);

    // OUT_REG=1 streaming: 40 cycles push+pop, no bubbles
    push1 = 1'b1; d1_in = 16'd0;
    tick();
    d1_in = 16'd1;
    tick();
    chk("st_pre_val", val1, 1); chk("st_pre_lvl", lvl1, 2);
    pop1 = 1'b1;
    for (int n = 0; n < 40; n++) begin
      d1_in = 16'(n + 2);
      chk("st_val", val1, 1);
      chk("st_data", d1_out, n);
      tick();
    end
    push1 = 1'b0;
    chk("st_tail0", d1_out, 40);
    tick();
    chk("st_tail1", d1_out, 41);
    tick();
    pop1 = 1'b0;
    chk("st_end_lvl", lvl1, 0); chk("st_end_val", val1, 0);

    // OUT_REG=1 capacity is DEPTH including the output register
    push1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d1_in = 16'(16'h100 + i);
      tick();
    end
    chk("or_full_lvl", lvl1, 16); chk("or_full_acc", acc1, 0);
    chk("or_full_af", af1, 1);    chk("or_full_head", d1_out, 16'h100);
    tick();
    push1 = 1'b0;
    chk("or_ovf", ovf1, 1);       chk("or_ovf_lvl", lvl1, 16);
    flush1 = 1'b1;
    tick();
    flush1 = 1'b0;
    chk("or_flush_lvl", lvl1, 0); chk("or_flush_val", val1, 0);
    chk("or_flush_ovf", ovf1, 1);

    // Asynchronous reset mid-burst
    push0 = 1'b1; push1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d0_in = 16'(i); d1_in = 16'(i);
      tick();
    end
    #3;
    rst = 1'b1;
    #1;
    chk("ar_lvl0", lvl0, 0); chk("ar_val0", val0, 0); chk("ar_acc0", acc0, 1);
    chk("ar_ae0", ae0, 1);   chk("ar_lvl1", lvl1, 0); chk("ar_val1", val1, 0);
    chk("ar_ovf1", ovf1, 0);
    push0 = 1'b0; push1 = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Wrap: 3*DEPTH pushes with concurrent pops (OUT_REG=0)
    push0 = 1'b1;
    for (int k = 0; k < 48; k++) begin
      d0_in = 16'(16'h200 + k);
      pop0 = (k > 0);
      if (k > 0) chk("wrap_data", d0_out, 16'h200 + k - 1);
      tick();
    end
    push0 = 1'b0; pop0 = 1'b1;
    chk("wrap_last", d0_out, 16'h22F);
    tick();
    pop0 = 1'b0;
    chk("wrap_lvl", lvl0, 0); chk("wrap_ovf", ovf0, 0); chk("wrap_udf", udf0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
